// File: rtl/perf_counter_bank_if.sv
// Purpose : groups the run-control, event and shadow-readout signals of perf_counter_bank.
// Latency : none, wires only.
// Backpressure : none; every signal is a level or single-cycle pulse, there is no handshake.
// master = controller side (drives start/stop/clear/evt/edge_mode/snap/rd_sel),
// slave  = counter bank (drives rd_data/ovf/running/halted).
// PERF_CNT_THRESH_EN adds thresh (to the bank) and thresh_hit (from the bank).
interface perf_counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = 2
);
  logic              start;
  logic              stop;
  logic              clear;
  logic [NUM_CH-1:0] evt;        // per-channel event inputs
  logic [NUM_CH-1:0] edge_mode;  // 1 = count rising edges, 0 = count high cycles
  logic              snap;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] ovf;
  logic              running;
  logic              halted;
`ifdef PERF_CNT_THRESH_EN
  logic [CNT_W-1:0]  thresh;
  logic              thresh_hit;
`endif

  modport master (
`ifdef PERF_CNT_THRESH_EN
    output thresh,
    input  thresh_hit,
`endif
    output start, stop, clear, evt, edge_mode, snap, rd_sel,
    input  rd_data, ovf, running, halted
  );

  modport slave (
`ifdef PERF_CNT_THRESH_EN
    input  thresh,
    output thresh_hit,
`endif
    input  start, stop, clear, evt, edge_mode, snap, rd_sel,
    output rd_data, ovf, running, halted
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Purpose : NUM_CH event counters under a STOPPED/RUNNING/HALTED run FSM, with snapshot shadows.
// Latency : event sampled at edge N is in the live counter after edge N; rd_data follows the next snap.
// Backpressure : none; inputs are accepted every cycle.
// Ports   : clock_i (rising edge), reset_i (async, active low), bank_if (perf_counter_bank_if.slave):
//           start/stop/clear/snap pulses, evt/edge_mode per channel, rd_sel -> rd_data (shadow),
//           ovf sticky flags, running/halted state decodes.
// Optional: define PERF_CNT_THRESH_EN to add the channel-0 threshold compare (thresh / thresh_hit).
module perf_counter_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SEL_W       = 2,
  parameter bit SATURATE    = 1'b0,
  parameter bit STOP_ON_OVF = 1'b0
) (
  input logic                clock_i,
  input logic                reset_i,
  perf_counter_bank_if.slave bank_if
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e                       state_q, state_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0]            ovf_q, ovf_d;
  logic [NUM_CH-1:0]            evt_q;      // previous-cycle event, kept in every state
  logic [NUM_CH-1:0]            inc;
  logic                         counting;
  logic                         halt_req;
`ifdef PERF_CNT_THRESH_EN
  logic                         thresh_hit_q, thresh_hit_d;
  logic                         thresh_match;
`endif

  // clear beats increment, so a clear cycle can never produce an overflow or halt.
  assign counting = (state_q == ST_RUNNING) && !bank_if.clear;

  always_comb begin : cnt_next
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    inc      = '0;
    halt_req = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i] = counting && bank_if.evt[i] && (!bank_if.edge_mode[i] || !evt_q[i]);
      if (bank_if.clear) begin
        cnt_d[i]    = '0;
        shadow_d[i] = '0;
        ovf_d[i]    = 1'b0;
      end else begin
        // shadow captures the pre-increment value
        if (bank_if.snap) shadow_d[i] = cnt_q[i];
        if (inc[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_d[i] = 1'b1;
            cnt_d[i] = SATURATE ? CNT_MAX : '0;
            // a saturated counter that already flagged must not halt again
            if (!(SATURATE && ovf_q[i])) halt_req = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
`ifdef PERF_CNT_THRESH_EN
    thresh_match = counting && (cnt_q[0] == bank_if.thresh);
    thresh_hit_d = !bank_if.clear && (thresh_hit_q || thresh_match);
    if (thresh_match) halt_req = 1'b1;
`endif
  end

  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      ST_STOPPED: if (bank_if.start && !bank_if.stop) state_d = ST_RUNNING;
      ST_RUNNING: begin
        if (bank_if.stop)                    state_d = ST_STOPPED;
        else if (STOP_ON_OVF && halt_req)    state_d = ST_HALTED;
      end
      ST_HALTED:  if (bank_if.clear || bank_if.stop) state_d = ST_STOPPED;
      default:    state_d = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin : state_reg
    if (!reset_i) begin
      state_q      <= ST_STOPPED;
      cnt_q        <= '0;
      shadow_q     <= '0;
      ovf_q        <= '0;
      evt_q        <= '0;
`ifdef PERF_CNT_THRESH_EN
      thresh_hit_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      ovf_q        <= ovf_d;
      evt_q        <= bank_if.evt;
`ifdef PERF_CNT_THRESH_EN
      thresh_hit_q <= thresh_hit_d;
`endif
    end
  end

  always_comb begin : fsm_out
    bank_if.running = (state_q == ST_RUNNING);
    bank_if.halted  = (state_q == ST_HALTED);
  end

  // Unused rd_sel codes (>= NUM_CH) fall through to zero.
  always_comb begin : rd_mux
    bank_if.rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bank_if.rd_sel == SEL_W'(i)) bank_if.rd_data = shadow_q[i];
    end
  end

  assign bank_if.ovf = ovf_q;
`ifdef PERF_CNT_THRESH_EN
  assign bank_if.thresh_hit = thresh_hit_q;
`endif

endmodule
